// File: rtl/spi_word_assembler.sv
// rtl/spi_word_assembler.sv - packs SPI rx bytes into BYTES-wide words with valid/ready output
//
// Purpose:
//    Collects bytes strobed by rx_done into a partial buffer and commits a
//    word after BYTES bytes. The committed word is offered on a valid/ready
//    slot and mirrored, without handshake, on last_word. frame_sync aborts a
//    partial word. Sticky flags report overwritten words (overrun) and
//    discarded partial words (frag_err).
//
// Optional feature (macro SPI_WA_TIMEOUT_EN):
//    When defined, a partial word left idle for TIMEOUT_CYCLES clocks is
//    discarded as if frame_sync had arrived. When undefined, partial words
//    persist until completed or cleared by frame_sync.
//
// Ports:
//    clk         in   system clock
//    rst_n       in   synchronous active-low reset
//    rx_data     in   received byte, valid with rx_done
//    rx_done     in   one-cycle byte strobe
//    frame_sync  in   one-cycle frame boundary pulse, aborts partial word
//    word_data   out  assembled word, held while word_valid=1
//    word_valid  out  word available
//    word_ready  in   consumer accepts word_data when word_valid=1
//    last_word   out  most recently completed word
//    byte_idx    out  bytes collected in the current partial word
//    overrun     out  sticky: unaccepted word was overwritten
//    frag_err    out  sticky: partial word discarded
//    err_clr     in   clears overrun and frag_err

module spi_word_assembler #(
   parameter int BYTES          = 2,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 1000,
   localparam int IDX_W         = (BYTES > 1) ? $clog2(BYTES) : 1,
   localparam int W             = 8 * BYTES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_done,
   input  logic             frame_sync,
   output logic [W-1:0]     word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [W-1:0]     last_word,
   output logic [IDX_W-1:0] byte_idx,
   output logic             overrun,
   output logic             frag_err,
   input  logic             err_clr
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic [W-1:0]     buf_q, buf_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     word_q, word_d;
   logic             valid_q, valid_d;
   logic [W-1:0]     last_q, last_d;
   logic             overrun_q, overrun_d;
   logic             frag_q, frag_d;

   logic [W-1:0]     merged;
   logic             timeout_hit;
   int               lane;

`ifdef SPI_WA_TIMEOUT_EN
   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Idle counter only runs while a partial word is pending; any byte
   // restarts it. The expiry cycle discards the partial word.
   always_comb begin
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      if (rx_done || (idx_q == '0)) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         timeout_hit = 1'b1;
         cnt_d       = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      buf_d     = buf_q;
      idx_d     = idx_q;
      word_d    = word_q;
      valid_d   = valid_q;
      last_d    = last_q;
      // Clear first so a coincident error event below still sets the flag.
      overrun_d = err_clr ? 1'b0 : overrun_q;
      frag_d    = err_clr ? 1'b0 : frag_q;

      lane = (MSB_FIRST != 0) ? (BYTES - 1 - int'(idx_q)) : int'(idx_q);

      // Partial buffer with the incoming byte dropped into its lane.
      merged = buf_q;
      for (int j = 0; j < BYTES; j++) begin
         if (j == lane) begin
            merged[8*j +: 8] = rx_data;
         end
      end

      // Transfer empties the slot unless a commit reloads it below.
      if (valid_q && word_ready) begin
         valid_d = 1'b0;
      end

      // Abort has priority over a same-cycle byte.
      if (frame_sync || timeout_hit) begin
         idx_d = '0;
         buf_d = '0;
         if (idx_q != '0) begin
            frag_d = 1'b1;
         end
      end else if (rx_done) begin
         if (idx_q == LAST_IDX) begin
            word_d  = merged;
            last_d  = merged;
            valid_d = 1'b1;
            idx_d   = '0;
            buf_d   = '0;
            if (valid_q && !word_ready) begin
               overrun_d = 1'b1;
            end
         end else begin
            buf_d = merged;
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q     <= '0;
         idx_q     <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= '0;
         overrun_q <= 1'b0;
         frag_q    <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         idx_q     <= idx_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         overrun_q <= overrun_d;
         frag_q    <= frag_d;
      end
   end

   assign word_data  = word_q;
   assign word_valid = valid_q;
   assign last_word  = last_q;
   assign byte_idx   = idx_q;
   assign overrun    = overrun_q;
   assign frag_err   = frag_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// tb/tb_spi_word_assembler.sv - scoreboard bench for spi_word_assembler

module tb_spi_word_assembler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_done2, rx_done4;
   logic        frame_sync;
   logic        word_ready;
   logic        err_clr;

   logic [15:0] wd2, lw2;
   logic        wv2, ov2, fe2;
   logic [0:0]  bi2;
   logic [31:0] wd4, lw4;
   logic        wv4, ov4, fe4;
   logic [1:0]  bi4;

   int checks = 0;
   int errors = 0;
   logic [63:0] q2[$];
   logic [63:0] q4[$];

   always #5 clk = ~clk;

   spi_word_assembler #(.BYTES(2), .MSB_FIRST(1), .TIMEOUT_CYCLES(10)) dut2 (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done2),
      .frame_sync(frame_sync), .word_data(wd2), .word_valid(wv2),
      .word_ready(word_ready), .last_word(lw2), .byte_idx(bi2),
      .overrun(ov2), .frag_err(fe2), .err_clr(err_clr)
   );

   spi_word_assembler #(.BYTES(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(10)) dut4 (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done4),
      .frame_sync(frame_sync), .word_data(wd4), .word_valid(wv4),
      .word_ready(word_ready), .last_word(lw4), .byte_idx(bi4),
      .overrun(ov4), .frag_err(fe4), .err_clr(err_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int which, input logic [7:0] b);
      rx_data = b;
      if (which == 4) rx_done4 = 1'b1;
      else            rx_done2 = 1'b1;
      step();
      rx_done2 = 1'b0;
      rx_done4 = 1'b0;
   endtask

   // Monitor: every word seen while the consumer is ready must match the
   // next expected word for that instance.
   always @(negedge clk) begin
      if (rst_n && wv2 && word_ready) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon2_unexpected: got %0h expected none", wd2);
         end else begin
            chk("mon2_word", 64'(wd2), q2.pop_front());
         end
      end
      if (rst_n && wv4 && word_ready) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon4_unexpected: got %0h expected none", wd4);
         end else begin
            chk("mon4_word", 64'(wd4), q4.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; rx_data = 8'h00; rx_done2 = 1'b0; rx_done4 = 1'b0;
      frame_sync = 1'b0; word_ready = 1'b1; err_clr = 1'b0;
      step(); step();
      chk("rst_wd2", 64'(wd2), 0);  chk("rst_wv2", 64'(wv2), 0);
      chk("rst_lw2", 64'(lw2), 0);  chk("rst_bi2", 64'(bi2), 0);
      chk("rst_ov2", 64'(ov2), 0);  chk("rst_fe2", 64'(fe2), 0);
      chk("rst_wd4", 64'(wd4), 0);  chk("rst_wv4", 64'(wv4), 0);
      chk("rst_bi4", 64'(bi4), 0);
      rst_n = 1'b1;
      step();

      // Two-byte MSB-first word, one-cycle valid pulse.
      q2.push_back(64'h1234);
      send(2, 8'h12);
      chk("t1_bi_after_first", 64'(bi2), 1);
      chk("t1_wv_not_early", 64'(wv2), 0);
      send(2, 8'h34);
      chk("t1_wv_latency", 64'(wv2), 1);
      chk("t1_wd", 64'(wd2), 64'h1234);
      chk("t1_lw", 64'(lw2), 64'h1234);
      chk("t1_bi_wrap", 64'(bi2), 0);
      step();
      chk("t1_wv_drop", 64'(wv2), 0);
      chk("t1_lw_hold", 64'(lw2), 64'h1234);

      // Four-byte LSB-first word.
      q4.push_back(64'hDDCCBBAA);
      send(4, 8'hAA); chk("t2_bi1", 64'(bi4), 1);
      send(4, 8'hBB); chk("t2_bi2", 64'(bi4), 2);
      send(4, 8'hCC); chk("t2_bi3", 64'(bi4), 3);
      chk("t2_wv_not_early", 64'(wv4), 0);
      send(4, 8'hDD); chk("t2_bi0", 64'(bi4), 0);
      chk("t2_wv", 64'(wv4), 1);
      chk("t2_lw", 64'(lw4), 64'hDDCCBBAA);
      step();

      // Overrun with consumer stalled, then err_clr.
      word_ready = 1'b0;
      q2.push_back(64'h0304);
      send(2, 8'h01); send(2, 8'h02);
      chk("t3_first_wv", 64'(wv2), 1);
      chk("t3_no_ov_yet", 64'(ov2), 0);
      send(2, 8'h03);
      chk("t3_wd_held", 64'(wd2), 64'h0102);
      send(2, 8'h04);
      chk("t3_wd", 64'(wd2), 64'h0304);
      chk("t3_wv", 64'(wv2), 1);
      chk("t3_ov", 64'(ov2), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("t3_ov_clr", 64'(ov2), 0);
      chk("t3_wv_stays", 64'(wv2), 1);
      word_ready = 1'b1;
      step();
      chk("t3_wv_drop", 64'(wv2), 0);

      // frame_sync aborts a partial word.
      q2.push_back(64'h6677);
      send(2, 8'h55);
      frame_sync = 1'b1; step(); frame_sync = 1'b0;
      chk("t4_bi_abort", 64'(bi2), 0);
      chk("t4_fe", 64'(fe2), 1);
      chk("t4_no_word", 64'(wv2), 0);
      send(2, 8'h66); send(2, 8'h77);
      chk("t4_wd", 64'(wd2), 64'h6677);
      chk("t4_lw", 64'(lw2), 64'h6677);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      chk("t4_fe_clr", 64'(fe2), 0);
      // Byte coincident with frame_sync is dropped; no fragment at idx 0.
      rx_data = 8'h88; rx_done2 = 1'b1; frame_sync = 1'b1;
      step();
      rx_done2 = 1'b0; frame_sync = 1'b0;
      chk("t4_coinc_bi", 64'(bi2), 0);
      chk("t4_coinc_fe", 64'(fe2), 0);
      chk("t4_coinc_lw", 64'(lw2), 64'h6677);
      // Error event coincident with err_clr wins.
      send(2, 8'h11);
      frame_sync = 1'b1; err_clr = 1'b1; step();
      frame_sync = 1'b0; err_clr = 1'b0;
      chk("t4_evt_wins", 64'(fe2), 1);
      chk("t4_evt_bi", 64'(bi2), 0);

      // Reset in the middle of a word.
      send(2, 8'h11);
      rst_n = 1'b0; step();
      chk("t5_wd", 64'(wd2), 0);  chk("t5_lw", 64'(lw2), 0);
      chk("t5_bi", 64'(bi2), 0);  chk("t5_fe", 64'(fe2), 0);
      chk("t5_wv", 64'(wv2), 0);  chk("t5_ov", 64'(ov2), 0);
      rst_n = 1'b1;
      q2.push_back(64'h2233);
      send(2, 8'h22); send(2, 8'h33);
      chk("t5_word", 64'(lw2), 64'h2233);
      step();

`ifdef SPI_WA_TIMEOUT_EN
      send(2, 8'h99);
      repeat (9) step();
      chk("t6_bi_before", 64'(bi2), 1);
      chk("t6_fe_before", 64'(fe2), 0);
      step();
      chk("t6_bi_timeout", 64'(bi2), 0);
      chk("t6_fe_timeout", 64'(fe2), 1);
      q2.push_back(64'hABCD);
      send(2, 8'hAB); send(2, 8'hCD);
      chk("t6_wd", 64'(wd2), 64'hABCD);
      step();
`else
      send(2, 8'h99);
      repeat (20) step();
      chk("t6_bi_persist", 64'(bi2), 1);
      chk("t6_fe_none", 64'(fe2), 0);
      q2.push_back(64'h99CD);
      send(2, 8'hCD);
      chk("t6_wd", 64'(wd2), 64'h99CD);
      step();
`endif

      repeat (3) step();
      chk("q2_drained", 64'(q2.size()), 0);
      chk("q4_drained", 64'(q4.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
